// File: rtl/bus_pkg.sv
// Shared definitions for the bus device endpoint: ID width, packet helpers and
// the bit positions of the sticky error flags.
package bus_pkg;

    localparam int ID_W      = 8;
    localparam int PKT_MAX_W = 64;

    localparam int ERR_RX_DROPPED    = 0;
    localparam int ERR_POP_UNDERFLOW = 1;
    localparam int ERR_RX_OVERFLOW   = 2;

    // Destination ID lives in the top byte of a packet of width pckg_sz.
    function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int pckg_sz);
        return ID_W'(pkt >> (pckg_sz - ID_W));
    endfunction

endpackage

// File: rtl/bus_dev_endpoint_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head, explicit occupancy count,
// full and empty. Writes while full and reads while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_dev_endpoint.sv
// Device-side bus endpoint: TX FIFO drained by the bus, RX FIFO filled by the bus,
// sticky error flags. Define DEV_ADDR_FILTER_EN to accept only packets for DEV_ID/BROADCAST.
module bus_dev_endpoint
    import bus_pkg::*;
#(
    parameter int              PCKG_SZ   = 16,
    parameter int              DEPTH     = 8,
    parameter logic [ID_W-1:0] DEV_ID    = 8'h00,
    parameter logic [ID_W-1:0] BROADCAST = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     pndng,
    output logic [PCKG_SZ-1:0]       D_pop,
    input  logic                     pop,
    input  logic                     push,
    input  logic [PCKG_SZ-1:0]       D_push,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    input  logic [PCKG_SZ-1:0]       tx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [PCKG_SZ-1:0]       rx_data,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic [2:0]               err_flags
);

    logic tx_full;
    logic tx_empty;
    logic rx_full;
    logic rx_empty;
    logic addr_ok;
    logic rx_accept;

    sync_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_valid),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (D_pop),
        .count   (tx_count),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    sync_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx_accept),
        .wr_data (D_push),
        .rd_en   (rx_ready),
        .rd_data (rx_data),
        .count   (rx_count),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    assign pndng    = !tx_empty;
    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;

`ifdef DEV_ADDR_FILTER_EN
    logic [ID_W-1:0] dest;
    assign dest    = dest_of(PKT_MAX_W'(D_push), PCKG_SZ);
    assign addr_ok = (dest == DEV_ID) || (dest == BROADCAST);
`else
    assign addr_ok = 1'b1;
`endif

    assign rx_accept = push && addr_ok;

    // Overflow only counts packets that passed the filter; fullness is judged before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flags <= '0;
        end else begin
            if (rx_accept && rx_full) begin
                err_flags[ERR_RX_OVERFLOW] <= 1'b1;
            end
            if (pop && tx_empty) begin
                err_flags[ERR_POP_UNDERFLOW] <= 1'b1;
            end
            if (push && !addr_ok) begin
                err_flags[ERR_RX_DROPPED] <= 1'b1;
            end
        end
    end

endmodule
